// File: rtl/stream_mux_arb.sv
// stream_mux_arb: NCH-way valid/ready stream mux, fixed-select or round-robin, with a registered output stage
`timescale 1ns/1ps
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH = 32,
  parameter int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [SELW-1:0] ptr, gnt;
  logic has, load_en;
  logic [WIDTH-1:0] words [NCH];
  for (genvar k = 0; k < NCH; k++) begin : g_words
    assign words[k] = in_data[k*WIDTH +: WIDTH];
  end
  assign load_en = !out_valid || out_ready;
  // Reverse scan so the channel closest to ptr (in rotated order) wins last.
  always_comb begin
    has = 1'b0;
    gnt = '0;
    if (!mode) begin
      has = (int'(sel) < NCH) && in_valid[sel];
      gnt = sel;
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (in_valid[(int'(ptr) + i) % NCH]) begin
          has = 1'b1;
          gnt = SELW'((int'(ptr) + i) % NCH);
        end
      end
    end
  end
  assign in_ready = (rst_n && load_en && has) ? (NCH'(1) << gnt) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= has;
      if (has) begin
        out_data <= words[gnt];
        out_ch   <= gnt;
        if (mode) ptr <= (int'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: randomized scoreboard bench for stream_mux_arb against a rotated-distance reference model
`timescale 1ns/1ps
module tb_stream_mux_arb;
  localparam int WIDTH = 8, NCH = 32, SELW = 5;
  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic [NCH*WIDTH-1:0] in_data = '0;
  logic [NCH-1:0] in_valid = '0, in_ready;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_valid;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [WIDTH-1:0] d; logic [SELW-1:0] c;} word_t;
  word_t q[$];
  int mptr = 0;
  bit mov = 1'b0;
  bit hv = 1'b0;
  logic [WIDTH-1:0] hd;
  logic [SELW-1:0] hc;

  always #5 clk = ~clk;

  stream_mux_arb #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner is the valid channel at the smallest rotated distance from the pointer.
  function automatic int ref_grant();
    int best = -1, bd = NCH;
    if (!mode) return (int'(sel) < NCH && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < NCH; k++)
      if (in_valid[k] && ((k - mptr + NCH) % NCH) < bd) begin
        bd = (k - mptr + NCH) % NCH;
        best = k;
      end
    return best;
  endfunction

  always @(negedge clk) begin
    int g;
    bit le;
    logic [NCH-1:0] er;
    #1;
    if (!rst_n) begin
      q.delete();
      mptr = 0;
      mov = 1'b0;
      chk("ready_in_reset", in_ready, 0);
    end else begin
      le = !mov || out_ready;
      g = ref_grant();
      er = (le && g >= 0) ? (NCH'(1) << g) : '0;
      chk("in_ready", in_ready, er);
      if (le) begin
        mov = (g >= 0);
        if (g >= 0) begin
          q.push_back({in_data[g*WIDTH +: WIDTH], SELW'(g)});
          if (mode) mptr = (g + 1) % NCH;
        end
      end
    end
  end

  always @(negedge clk) begin
    word_t w;
    if (!rst_n) hv = 1'b0;
    else begin
      chk("out_valid", out_valid, mov);
      if (hv) begin
        chk("hold_data", out_data, hd);
        chk("hold_ch", out_ch, hc);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got ch %0d data %0h expected none at %0t", out_ch, out_data, $time);
        end else begin
          w = q.pop_front();
          chk("out_data", out_data, w.d);
          chk("out_ch", out_ch, w.c);
        end
      end
      hv = out_valid && !out_ready;
      hd = out_data;
      hc = out_ch;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_ready", in_ready, 0);
    cyc(2);
    rst_n = 1'b1;
    mode = 1'b0; sel = 5; in_valid = '0; in_valid[5] = 1'b1; in_valid[9] = 1'b1;
    in_data[5*WIDTH +: WIDTH] = 8'h55; in_data[9*WIDTH +: WIDTH] = 8'h99; out_ready = 1'b1;
    #1 chk("fixed_ready", in_ready, 32'h0000_0020);
    cyc(4);
    mode = 1'b1; in_valid = '1;
    for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(k);
    cyc(34);
    in_valid = '0; in_valid[30] = 1'b1;
    cyc(1);
    in_valid[3] = 1'b1;
    #1 chk("wrap_first", in_ready, 32'h0000_0008);
    cyc(4);
    in_valid = '1; out_ready = 1'b0;
    cyc(4);
    out_ready = 1'b1;
    cyc(3);
    mode = 1'b0; sel = 31; in_valid = '1; in_valid[31] = 1'b0;
    cyc(3);
    chk("sel31_drop", out_valid, 0);
    mode = 1'b1;
    cyc(3);
    repeat (500) begin
      mode = 1'($urandom_range(0, 1));
      sel = SELW'($urandom);
      in_valid = $urandom & $urandom;
      for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    mode = 1'b1; in_valid = '1; out_ready = 1'b0;
    cyc(2);
    #1 chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ch", out_ch, 0);
    chk("mid_rst_ready", in_ready, 0);
    cyc(2);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("post_reset_grant", in_ready, 32'h0000_0001);
    cyc(5);
    in_valid = '0;
    cyc(3);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
